// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART frame parser: FSM encoding, error codes and
// default header bytes.
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StGotH0   = 3'd1,
        StGetLen  = 3'd2,
        StPayload = 3'd3,
        StGetCsum = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_parser_timeout.sv
// Inter-byte idle counter: clears on demand, counts while enabled and flags expiry once the
// count reaches TIMEOUT_CYC.
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == LIMIT);

    // Saturate at the limit so a stalled enable cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Parses HDR0 HDR1 LEN payload CSUM frames from a UART byte stream, streams the payload
// out one clock after each byte and reports a pass/fail status per frame.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1        = HDR1_DEFAULT,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_last,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [1:0] err_code
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] pl_data_q, pl_data_d;
    logic       pl_valid_q, pl_valid_d;
    logic       pl_last_q, pl_last_d;
    logic       done_q, done_d;
    logic       ok_q, ok_d;
    logic [1:0] err_q, err_d;
    logic       tmo_expired;

    frame_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (rx_valid || (state_q == StIdle)),
        .enable (state_q != StIdle),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        pl_data_d  = pl_data_q;
        pl_valid_d = 1'b0;
        pl_last_d  = 1'b0;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_d      = err_q;

        // A byte arriving in the expiry cycle wins over the timeout.
        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == HDR0) state_d = StGotH0;
                end
                StGotH0: begin
                    if (rx_data == HDR1) begin
                        state_d = StGetLen;
                    end else if (rx_data != HDR0) begin
                        state_d = StIdle;
                    end
                end
                StGetLen: begin
                    len_d = rx_data;
                    acc_d = rx_data;
                    cnt_d = '0;
                    if (rx_data == 8'd0) begin
                        state_d = StGetCsum;
                    end else if (rx_data > MAX_LEN_B) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        ok_d    = 1'b0;
                        err_d   = ERR_LEN;
                    end else begin
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    pl_data_d  = rx_data;
                    pl_valid_d = 1'b1;
                    acc_d      = acc_q + rx_data;
                    cnt_d      = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == len_q) begin
                        pl_last_d = 1'b1;
                        state_d   = StGetCsum;
                    end
                end
                StGetCsum: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (rx_data == acc_q) begin
                        ok_d  = 1'b1;
                        err_d = ERR_NONE;
                    end else begin
                        ok_d  = 1'b0;
                        err_d = ERR_CSUM;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (tmo_expired) begin
            state_d = StIdle;
            // A lone HDR0 is not yet a frame, so it expires without a report.
            if (state_q != StGotH0) begin
                done_d = 1'b1;
                ok_d   = 1'b0;
                err_d  = ERR_TMO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pl_data_q  <= '0;
            pl_valid_q <= 1'b0;
            pl_last_q  <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            pl_data_q  <= pl_data_d;
            pl_valid_q <= pl_valid_d;
            pl_last_q  <= pl_last_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign pl_data    = pl_data_q;
    assign pl_valid   = pl_valid_q;
    assign pl_last    = pl_last_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, oversize length, resync, timeouts,
// same-cycle byte/timeout priority and mid-frame reset.
module tb_uart_frame_parser;
    import uart_frame_parser_pkg::*;

    localparam int unsigned TMO = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       frame_done;
    logic       frame_ok;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] pl_q[$];    // {pl_last, pl_data}
    logic [2:0] done_q[$];  // {frame_ok, err_code}
    int         both_cnt = 0;

    uart_frame_parser #(
        .HDR0       (8'h55),
        .HDR1       (8'hAA),
        .MAX_LEN    (16),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pl_data   (pl_data),
        .pl_valid  (pl_valid),
        .pl_last   (pl_last),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pl_valid) pl_q.push_back({pl_last, pl_data});
        if (frame_done) done_q.push_back({frame_ok, err_code});
        if (pl_valid && frame_done) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // exp_pl packs up to four {last,data} entries, entry i at bits [9*i +: 9].
    task automatic expect_frame(input string tag, input int npl, input logic [35:0] exp_pl,
                                input int ndone, input logic [2:0] exp_done);
        check({tag, "_npl"}, pl_q.size(), npl);
        for (int i = 0; i < npl && i < pl_q.size(); i++) begin
            check($sformatf("%s_pl%0d", tag, i), {23'd0, pl_q[i]}, {23'd0, exp_pl[9*i +: 9]});
        end
        check({tag, "_ndone"}, done_q.size(), ndone);
        if (ndone > 0 && done_q.size() > 0) begin
            check({tag, "_status"}, {29'd0, done_q[0]}, {29'd0, exp_done});
        end
        pl_q.delete();
        done_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pl_data"}, {24'd0, pl_data}, 32'd0);
        check({tag, "_pl_valid"}, {31'd0, pl_valid}, 32'd0);
        check({tag, "_pl_last"}, {31'd0, pl_last}, 32'd0);
        check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_ok"}, {31'd0, frame_ok}, 32'd0);
        check({tag, "_err"}, {30'd0, err_code}, 32'd0);
    endtask

    initial begin
        int lat;

        // Reset state
        #2 rst_n = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        check("reset_state", 32'(dut.state_q), 32'(StIdle));
        rst_n = 1'b1;
        idle(2);

        // Good frame: 55 AA 03 11 22 33 69
        send(8'h55); send(8'hAA); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        idle(3);
        expect_frame("good", 3, {9'h000, 9'h133, 9'h022, 9'h011}, 1, {1'b1, ERR_NONE});

        // Bad checksum: 55 AA 02 01 02 00 (expected sum 05)
        send(8'h55); send(8'hAA); send(8'h02);
        send(8'h01); send(8'h02); send(8'h00);
        idle(3);
        expect_frame("badcs", 2, {9'h000, 9'h000, 9'h102, 9'h001}, 1, {1'b0, ERR_CSUM});
        idle(5);
        check("badcs_hold_ok", {31'd0, frame_ok}, 32'd0);
        check("badcs_hold_err", {30'd0, err_code}, 32'(ERR_CSUM));

        // Oversize length, then a good frame 55 AA 01 7F 80
        send(8'h55); send(8'hAA); send(8'h11);
        idle(3);
        expect_frame("oversize", 0, 36'd0, 1, {1'b0, ERR_LEN});
        send(8'h55); send(8'hAA); send(8'h01); send(8'h7F); send(8'h80);
        idle(3);
        expect_frame("after_ovs", 1, {27'd0, 9'h17F}, 1, {1'b1, ERR_NONE});

        // Header resync with zero-length payload: 55 55 AA 00 00
        send(8'h55); send(8'h55); send(8'hAA); send(8'h00); send(8'h00);
        idle(3);
        expect_frame("resync", 0, 36'd0, 1, {1'b1, ERR_NONE});

        // Timeout mid-payload: 55 AA 02 01 then silence
        send(8'h55); send(8'hAA); send(8'h02); send(8'h01);
        lat = 0;
        for (int i = 1; i <= TMO + 10; i++) begin
            @(posedge clk);
            #1;
            if (frame_done && lat == 0) lat = i;
        end
        check("tmo_latency", lat, TMO + 1);
        check("tmo_state", 32'(dut.state_q), 32'(StIdle));
        idle(1);
        expect_frame("tmo", 1, {27'd0, 9'h001}, 1, {1'b0, ERR_TMO});

        // Lone HDR0 expires silently
        send(8'h55);
        idle(TMO + 5);
        expect_frame("h0_tmo", 0, 36'd0, 0, 3'd0);
        check("h0_tmo_state", 32'(dut.state_q), 32'(StIdle));

        // Byte landing exactly in the expiry cycle is processed: 55 AA 01 [wait] 05 06
        send(8'h55); send(8'hAA); send(8'h01);
        idle(TMO - 1);
        send(8'h05);
        send(8'h06);
        idle(3);
        expect_frame("tmo_edge", 1, {27'd0, 9'h105}, 1, {1'b1, ERR_NONE});

        // Reset mid-payload: 55 AA 04 01, reset while the payload strobe is high
        send(8'h55); send(8'hAA); send(8'h04);
        @(negedge clk);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        @(posedge clk);
        #2 rx_valid = 1'b0;
        check("rst_pre_valid", {31'd0, pl_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        idle(3);
        rst_n = 1'b1;
        check("midrst_ndone", done_q.size(), 0);
        pl_q.delete();
        send(8'h55); send(8'hAA); send(8'h02); send(8'h03); send(8'h04); send(8'h09);
        idle(3);
        expect_frame("post_rst", 2, {9'h000, 9'h000, 9'h104, 9'h003}, 1, {1'b1, ERR_NONE});

        check("valid_done_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter HDR0, default 8'h55, meaning first header byte.
REQ-002 SHALL have parameter HDR1, default 8'hAA, meaning second header byte.
REQ-003 SHALL have parameter MAX_LEN, default 16, meaning the largest legal payload length in bytes (1..255).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 10000, meaning the maximum idle clocks allowed between bytes inside a frame.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous and active-low.
REQ-007 rx_data  input  8  received byte from the UART receiver.
REQ-008 rx_valid  input  1  one-clock strobe qualifying rx_data.
REQ-009 pl_data  output  8  payload byte.
REQ-010 pl_valid  output  1  one-clock strobe qualifying pl_data.
REQ-011 pl_last  output  1  asserted with pl_valid on the final payload byte.
REQ-012 frame_done  output  1  one-clock strobe marking the end of a frame, whether it passed or failed.
REQ-013 frame_ok  output  1  valid with frame_done; 1 = checksum matched.
REQ-014 err_code  output  2  valid with frame_done: 0 none, 1 checksum, 2 length, 3 timeout.

Function
REQ-015 Frame format SHALL be: HDR0, HDR1, LEN, LEN payload bytes, CSUM.
- CSUM = (LEN + sum of payload bytes) mod 256, 8-bit wrap.
REQ-016 The FSM states SHALL be IDLE, GOT_H0, GET_LEN, PAYLOAD, GET_CSUM.
- The FSM advances only on rx_valid, except on timeout.
REQ-017 IDLE: byte == HDR0 -> GOT_H0; any other byte is ignored.
REQ-018 GOT_H0: byte == HDR1 -> GET_LEN.
- byte == HDR0 -> stay in GOT_H0.
- any other byte -> IDLE.
- No frame_done on these transitions.
REQ-019 GET_LEN: the byte is latched as LEN and loaded into the checksum accumulator.
- LEN == 0 -> GET_CSUM.
- 1 <= LEN <= MAX_LEN -> PAYLOAD.
- LEN > MAX_LEN -> IDLE with frame_done=1, frame_ok=0, err_code=2.
REQ-020 PAYLOAD: each byte drives pl_data/pl_valid exactly 1 clock after its rx_valid cycle, and is added to the accumulator.
- pl_last is asserted on byte number LEN.
- After byte LEN -> GET_CSUM.
REQ-021 GET_CSUM: the byte is compared with the accumulator, the FSM returns to IDLE, and frame_done pulses 1 clock after rx_valid.
- Match: frame_ok=1, err_code=0.
- Mismatch: frame_ok=0, err_code=1.
REQ-022 Timeout: the inter-byte counter clears on every rx_valid and counts in every non-IDLE state.
- When the count reaches TIMEOUT_CYC: go to IDLE with frame_done=1, frame_ok=0, err_code=3.
- A timeout in GOT_H0 returns to IDLE silently.
REQ-023 If rx_valid and the timeout occur in the same cycle, rx_valid SHALL take priority: the byte is processed and the counter clears.
REQ-024 Payload bytes already emitted SHALL NOT be retracted on a failure; the downstream consumer uses frame_ok to accept or discard them.
REQ-025 pl_valid, pl_last and frame_done SHALL each be single-cycle pulses.
- pl_valid and frame_done are never asserted in the same cycle.
REQ-026 frame_ok and err_code SHALL hold their value until the next frame_done.
REQ-027 Back-to-back frames SHALL be accepted: a HDR0 byte on the rx_valid immediately following CSUM starts a new frame.

Reset
REQ-028 While rst_n is low, the following SHALL apply:
- FSM = IDLE.
- pl_data=0, pl_valid=0, pl_last=0.
- frame_done=0, frame_ok=0, err_code=0.
- Accumulator, byte counter and timeout counter = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no frame_done; parsing resumes from IDLE on the first clock after rst_n rises.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state encoding;
- the err_code constants ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TMO;
- the default header values.
REQ-031 The timeout counter SHALL be a sub-module named frame_timeout, with inputs clear and enable and output expired; it is sized $clog2(TIMEOUT_CYC+1).
REQ-032 The block SHALL sit downstream of uart_rx, taking rx_data/rx_valid directly with no buffering.

Verification
REQ-033 Good frame: 55 AA 03 11 22 33 69.
- pl_data 11, 22, 33; pl_last on 33.
- frame_done with frame_ok=1, err_code=0.
REQ-034 Bad checksum: 55 AA 02 01 02 00.
- Payload 01, 02 emitted.
- frame_done with frame_ok=0, err_code=1.
REQ-035 Oversize length: 55 AA 11 with MAX_LEN=16.
- frame_done with err_code=2, no pl_valid.
- A following good frame parses correctly.
REQ-036 Header resync: 55 55 AA 00 00.
- frame_done with frame_ok=1, zero pl_valid.
REQ-037 Timeout: 55 AA 02 01, then silence for TIMEOUT_CYC clocks.
- frame_done with err_code=3.
- The FSM is in IDLE afterwards.
REQ-038 Reset mid-payload: drop rst_n after 55 AA 04 01.
- All outputs go to 0 immediately, with no frame_done.
- After rst_n releases, a good frame passes.
